// File: rtl/psychic5_video_pkg.sv
// psychic5_video_pkg: shared raster geometry constants, RGB word type and range helper
package psychic5_video_pkg;
  localparam logic [8:0] H_MIN       = 9'd128;
  localparam logic [8:0] H_MAX       = 9'd511;
  localparam logic [8:0] V_MIN       = 9'd248;
  localparam logic [8:0] V_MAX       = 9'd511;
  localparam logic [8:0] HACT_START  = 9'd269;
  localparam logic [8:0] HACT_END    = 9'd140;
  localparam logic [8:0] VACT_FIRST  = 9'd272;
  localparam logic [8:0] VACT_LAST   = 9'd495;
  localparam logic [8:0] HSYNC_START = 9'd176;
  localparam logic [8:0] HSYNC_END   = 9'd207;
  localparam logic [8:0] VSYNC_START = 9'd504;
  localparam logic [8:0] VSYNC_END   = 9'd511;
  typedef logic [11:0] rgb12;
  function automatic logic in_rng(input logic [8:0] x, input logic [8:0] lo, input logic [8:0] hi);
    return (x >= lo) && (x <= hi);
  endfunction
endpackage

// File: rtl/psychic5_video_timing_if.sv
// psychic5_video_timing_if: pixel-enable, palette input and raster/video outputs (i_TESTPAT under PSYCHIC5_VTIMING_TESTPATTERN_EN)
interface psychic5_video_timing_if;
  import psychic5_video_pkg::*;
  logic       i_EMU_CLK6MPCEN_n;
  rgb12       i_PALETTE_DATA;
`ifdef PSYCHIC5_VTIMING_TESTPATTERN_EN
  logic       i_TESTPAT;
`endif
  logic [8:0] o_HCOUNTER;
  logic [8:0] o_VCOUNTER;
  logic       o_HBLANK_n;
  logic       o_VBLANK_n;
  logic       o_HSYNC_n;
  logic       o_VSYNC_n;
  logic       o_FRAME_START;
  rgb12       o_VIDEODATA;
  modport master (
    output i_EMU_CLK6MPCEN_n, i_PALETTE_DATA,
`ifdef PSYCHIC5_VTIMING_TESTPATTERN_EN
    i_TESTPAT,
`endif
    input o_HCOUNTER, o_VCOUNTER, o_HBLANK_n, o_VBLANK_n, o_HSYNC_n, o_VSYNC_n, o_FRAME_START, o_VIDEODATA
  );
  modport slave (
    input i_EMU_CLK6MPCEN_n, i_PALETTE_DATA,
`ifdef PSYCHIC5_VTIMING_TESTPATTERN_EN
    i_TESTPAT,
`endif
    output o_HCOUNTER, o_VCOUNTER, o_HBLANK_n, o_VBLANK_n, o_HSYNC_n, o_VSYNC_n, o_FRAME_START, o_VIDEODATA
  );
endinterface

// File: rtl/psychic5_video_outreg.sv
// psychic5_video_outreg: blank-masked RGB output register with optional test pattern (PSYCHIC5_VTIMING_TESTPATTERN_EN)
module psychic5_video_outreg
  import psychic5_video_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       ce_i,
  input  logic       act_i,
  input  rgb12       pal_i,
`ifdef PSYCHIC5_VTIMING_TESTPATTERN_EN
  input  logic       tp_i,
  input  logic [3:0] hn_i,
  input  logic [3:0] vn_i,
`endif
  output rgb12       vid_o
);
  rgb12 vid_d;
  rgb12 vid_q;
`ifdef PSYCHIC5_VTIMING_TESTPATTERN_EN
  // pixel for the upcoming position: pattern or palette, black when blanked
  always_comb vid_d = act_i ? (tp_i ? {hn_i, hn_i, vn_i} : pal_i) : '0;
`else
  // pixel for the upcoming position: palette, black when blanked
  always_comb vid_d = act_i ? pal_i : '0;
`endif
  // latch on pixel-enable so data stays aligned with the counters
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) vid_q <= '0;
    else if (ce_i) vid_q <= vid_d;
  assign vid_o = vid_q;
endmodule

// File: rtl/psychic5_video_timing.sv
// psychic5_video_timing: H/V counters, blanking, syncs, frame start and RGB output (optional PSYCHIC5_VTIMING_TESTPATTERN_EN)
module psychic5_video_timing
  import psychic5_video_pkg::*;
(
  input logic i_EMU_MCLK,
  input logic i_EMU_INITRST_n,
  psychic5_video_timing_if.slave vif
);
  logic [8:0] h_q, h_d, v_q, v_d;
  logic hbl_q, hbl_d, vact_q, vact_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
  logic ce;
  assign ce = !vif.i_EMU_CLK6MPCEN_n;
  // next raster position and the strobes that must accompany it
  always_comb begin
    h_d    = (h_q == H_MAX) ? H_MIN : h_q + 9'd1;
    v_d    = (h_q != H_MAX) ? v_q : (v_q == V_MAX) ? V_MIN : v_q + 9'd1;
    vact_d = (h_d == HACT_START) ? in_rng(v_d, VACT_FIRST, VACT_LAST) : vact_q;
    hbl_d  = (h_d >= HACT_START) || (h_d <= HACT_END);
    hs_d   = !in_rng(h_d, HSYNC_START, HSYNC_END);
    vs_d   = v_d < VSYNC_START;
    fs_d   = (h_d == HACT_START) && (v_d == VACT_FIRST);
  end
  // raster state advances only on pixel-enable
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n)
    if (!i_EMU_INITRST_n) begin
      h_q    <= H_MIN;
      v_q    <= V_MIN;
      hbl_q  <= 1'b0;
      vact_q <= 1'b0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      fs_q   <= 1'b0;
    end else if (ce) begin
      h_q    <= h_d;
      v_q    <= v_d;
      hbl_q  <= hbl_d;
      vact_q <= vact_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      fs_q   <= fs_d;
    end
  psychic5_video_outreg u_outreg (
    .clk_i   (i_EMU_MCLK),
    .rst_n_i (i_EMU_INITRST_n),
    .ce_i    (ce),
    .act_i   (hbl_d & vact_d),
    .pal_i   (vif.i_PALETTE_DATA),
`ifdef PSYCHIC5_VTIMING_TESTPATTERN_EN
    .tp_i    (vif.i_TESTPAT),
    .hn_i    (h_d[7:4]),
    .vn_i    (v_d[7:4]),
`endif
    .vid_o   (vif.o_VIDEODATA)
  );
  assign vif.o_HCOUNTER    = h_q;
  assign vif.o_VCOUNTER    = v_q;
  assign vif.o_HBLANK_n    = hbl_q;
  assign vif.o_VBLANK_n    = vact_q;
  assign vif.o_HSYNC_n     = hs_q;
  assign vif.o_VSYNC_n     = vs_q;
  assign vif.o_FRAME_START = fs_q;
endmodule
